// File: rtl/gpio_seq_monitor_if.sv
// Bus bundle for gpio_seq_monitor: table load port, run control, monitored bus and status.
interface gpio_seq_monitor_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic             start;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [WIDTH-1:0] load_data;
    logic [LW-1:0]    seq_len;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] io_in;
    logic             busy;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [LW-1:0]    match_idx;
    logic [WIDTH-1:0] last_seen;

    modport master (
        output start, load_en, load_addr, load_data, seq_len, mask, io_in,
        input  busy, pass, fail, timeout, match_idx, last_seen
    );

    modport slave (
        input  start, load_en, load_addr, load_data, seq_len, mask, io_in,
        output busy, pass, fail, timeout, match_idx, last_seen
    );
endinterface

// File: rtl/gpio_seq_monitor.sv
// GPIO sequence monitor: walks a table of expected bus values and reports pass/fail/timeout.
// Define GPIO_SEQ_MON_STRICT_EN to also fail on any unexpected intermediate bus value.
module gpio_seq_monitor #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input logic               clock,
    input logic               RSTB,
    gpio_seq_monitor_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] exp_table [DEPTH];
    logic [LW-1:0]    idx;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    len_clamped;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] expected;
    logic [TW-1:0]    timer;
    logic             timeout_q;
    logic             hit;
    logic             final_hit;
    logic             timer_end;
`ifdef GPIO_SEQ_MON_STRICT_EN
    logic [WIDTH-1:0] prev_q;
    logic             stray;
`endif

    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.io_in;
            s2 <= s1;
        end
    end

    // Table writes are locked out while a check runs or is being (re)started.
    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_table[i] <= '0;
            end
        end else if (bus.load_en && (state != ST_RUN) && !bus.start) begin
            exp_table[bus.load_addr] <= bus.load_data;
        end
    end

    assign len_clamped = (bus.seq_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.seq_len;
    assign sample      = s2 & mask_q;
    assign expected    = exp_table[idx[AW-1:0]] & mask_q;
    assign hit         = (len_q != '0) && (sample == expected);
    assign final_hit   = hit && (idx == len_q - LW'(1));
    assign timer_end   = (timer == TW'(TIMEOUT_CYCLES - 1));
`ifdef GPIO_SEQ_MON_STRICT_EN
    assign stray       = !hit && (sample != prev_q);
`endif

    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A final match beats a timeout landing on the same cycle.
    always_comb begin
        state_next = state;
        if (bus.start) begin
            state_next = ST_RUN;
        end else if (state == ST_RUN) begin
            if ((len_q == '0) || final_hit) begin
                state_next = ST_PASS;
            end else if (timer_end) begin
                state_next = ST_FAIL;
`ifdef GPIO_SEQ_MON_STRICT_EN
            end else if (stray) begin
                state_next = ST_FAIL;
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            idx       <= '0;
            len_q     <= '0;
            mask_q    <= '0;
            timer     <= '0;
            timeout_q <= 1'b0;
`ifdef GPIO_SEQ_MON_STRICT_EN
            prev_q    <= '0;
`endif
        end else if (bus.start) begin
            idx       <= '0;
            len_q     <= len_clamped;
            mask_q    <= bus.mask;
            timer     <= '0;
            timeout_q <= 1'b0;
`ifdef GPIO_SEQ_MON_STRICT_EN
            prev_q    <= s2 & bus.mask;
`endif
        end else if (state == ST_RUN) begin
            timer <= timer + TW'(1);
            if (hit) begin
                idx <= idx + LW'(1);
            end
            if (timer_end && !final_hit && (len_q != '0)) begin
                timeout_q <= 1'b1;
            end
`ifdef GPIO_SEQ_MON_STRICT_EN
            if (hit) begin
                prev_q <= sample;
            end
`endif
        end
    end

    always_comb begin
        bus.busy      = (state == ST_RUN);
        bus.pass      = (state == ST_PASS);
        bus.fail      = (state == ST_FAIL);
        bus.timeout   = timeout_q;
        bus.match_idx = idx;
        bus.last_seen = s2;
    end
endmodule

// File: doc/gpio_seq_monitor.md
# gpio_seq_monitor

Synthesizable, parametrised GPIO sequence monitor for on-chip self-test of the rv32 core's user I/O. It samples a WIDTH-bit output bus (normally mprj_io[WIDTH-1:0]) and checks it against a programmable table of expected values. It reports pass, fail or timeout without the management core or a simulation bench watching the pins. It sits beside the core in the user project and is loaded and started by the core or the housekeeping bus before a test program runs.

## Interface
- WIDTH, 8: monitored bus width.
- DEPTH, 16: maximum sequence length (table entries).
- TIMEOUT_CYCLES, 25000: cycles allowed in RUN before timeout fail; must be ≥1.
- clock  in  1  single clock, rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- start  in  1  pulse; (re)starts a check from entry 0.
- load_en  in  1  write load_data into table[load_addr].
- load_addr  in  $clog2(DEPTH)  table write address.
- load_data  in  WIDTH  expected value.
- seq_len  in  $clog2(DEPTH)+1  entries to check; values above DEPTH are clamped to DEPTH; sampled on start.
- mask  in  WIDTH  compare mask; 1 = bit compared; sampled on start.
- io_in  in  WIDTH  monitored bus; asynchronous to clock.
- busy  out  1  high in RUN.
- pass  out  1  sticky; full sequence matched.
- fail  out  1  sticky; timeout, or mismatch when strict mode is compiled in.
- timeout  out  1  sticky; fail was caused by timeout.
- match_idx  out  $clog2(DEPTH)+1  number of entries matched.
- last_seen  out  WIDTH  most recent synchronised io_in sample.

## Operation
- Input path: io_in passes through a 2-flop synchroniser (s1, s2); last_seen = s2. All compares use s2 & mask.
- Table: DEPTH×WIDTH flops, reset to 0. A write (load_en) takes effect at the clock edge and is ignored while busy or while start is high.
- FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE/PASS/FAIL + start → RUN. On entry: idx=0, timer=0, sticky flags cleared, seq_len and mask latched.
  - If the latched seq_len = 0, the FSM goes to PASS one cycle after start.
  - RUN: if (s2 & mask) == (table[idx] & mask), then idx++. If idx was len-1, the FSM goes to PASS.
  - RUN: timer increments each cycle. When timer == TIMEOUT_CYCLES-1 and no final match occurs that cycle, the FSM goes to FAIL with timeout=1.
  - RUN + start → restart (same as entry).
- At most one entry matches per cycle. Equal consecutive entries therefore match on consecutive cycles.
- Non-matching intermediate values are ignored (level-wait semantics).
- match_idx = idx. It holds its value in PASS/FAIL until the next start.

## Timing
- Reset values: busy=0, pass=0, fail=0, timeout=0, match_idx=0, last_seen=0, state=IDLE, s1=s2=0, table=0.
- Reset is asynchronous. Asserting it mid-run forces IDLE immediately; a fresh start is required afterwards.
- Latency: an io_in change set up before edge k is in s2 after edge k+1. The resulting match_idx/pass update is visible after edge k+2.
- busy rises the cycle after start and falls on the same edge that sets pass or fail.
- Final match and timeout in the same cycle: the match wins and the FSM goes to PASS.
- Timeout is measured globally from start; it is not reset by intermediate matches. fail fires exactly TIMEOUT_CYCLES cycles after busy rises.
- Timer width is $clog2(TIMEOUT_CYCLES+1). The timer does not wrap; it stops in FAIL.

## Configuration
- GPIO_SEQ_MON_STRICT_EN defined:
  - A prev register captures s2 & mask on RUN entry and on each match.
  - In RUN, if s2 & mask equals neither table[idx] & mask nor prev, the FSM goes to FAIL with timeout=0 one cycle later.
  - The monitored bus must change in a single cycle (software register writes).
- Not defined: no prev register, no mismatch fail. Only timeout can cause fail.

## Test plan
- Load 01..0A, FF, 00 (seq_len=12, mask=FF). Start, then drive each value for 5 cycles → pass=1 three edges after 00 is applied, match_idx=12, fail=0, busy=0.
- TIMEOUT_CYCLES=200, same table, stop driving after 05 → fail=1, timeout=1 exactly 200 cycles after busy rises, match_idx=5, pass=0.
- seq_len=0, start → pass=1 on the next cycle; seq_len=20 with DEPTH=16 → 16 entries are checked.
- mask=0F, table[0]=03, seq_len=1, drive A3 → pass=1; drive A4 instead → no match, ends in timeout.
- Strict build: table 01, 02; drive 01 then 07 → fail=1, timeout=0, last_seen=07, match_idx=1. Non-strict build, same stimulus → no fail; driving 02 afterwards gives pass=1.
- Assert RSTB mid-run (match_idx=3) → all outputs 0 immediately. After release, start with the reloaded table gives a normal pass. A load_en pulse while busy leaves the table unchanged.
